// File: rtl/keypad_time_entry.sv
// Keypad time-entry front end: debounced one-hot numpad to BCD shift register,
// per-digit active-low load strobe and a free-running divided square wave.
module keypad_time_entry #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned DIV_COUNT      = 100
) (
  input  logic                               clock_100Hz,
  input  logic                               reset,
  input  logic [9:0]                         numpad,
  input  logic                               enablen,
  input  logic                               clear,
  output logic [4*NUM_DIGITS-1:0]            D,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
  output logic                               loadn,
  output logic                               full,
  output logic                               pgt_1Hz
);

  localparam int unsigned DW   = 4 * NUM_DIGITS;
  localparam int unsigned CW   = $clog2(NUM_DIGITS + 1);
  localparam int unsigned DBW  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned DIVW = $clog2(DIV_COUNT);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state, state_n;
  logic [DBW-1:0]  cnt, cnt_n;
  logic [3:0]      code, code_n;
  logic [3:0]      key_code_c;
  logic            key_valid_c;
  logic            same_key_c;
  logic            accept_c;
  logic [DW-1:0]   d_shift_c;
  logic [DIVW-1:0] div_cnt;
  logic [DIVW-1:0] div_next_c;

  // One-hot to BCD encode; a key is valid only when exactly one bit is set
  always_comb begin
    key_code_c = '0;
    for (int k = 0; k < 10; k++) begin
      if (numpad[k]) key_code_c = 4'(k);
    end
    key_valid_c = (numpad != '0) && ((numpad & (numpad - 10'd1)) == '0);
    same_key_c  = key_valid_c && (key_code_c == code);
    d_shift_c   = (D << 4) | DW'(key_code_c);
  end

  // Debounce FSM state register
  always_ff @(posedge clock_100Hz) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      code  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      code  <= code_n;
    end
  end

  // Debounce FSM next-state: press qualification, hold, release qualification
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    code_n   = code;
    accept_c = 1'b0;
    case (state)
      IDLE: begin
        if (!enablen && key_valid_c) begin
          code_n = key_code_c;
          if (DEBOUNCE_TICKS == 1) begin
            accept_c = 1'b1;
            state_n  = HELD;
          end else begin
            cnt_n   = DBW'(1);
            state_n = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (!enablen && same_key_c) begin
          if (cnt == DBW'(DEBOUNCE_TICKS - 1)) begin
            accept_c = 1'b1;
            state_n  = HELD;
          end else begin
            cnt_n = cnt + DBW'(1);
          end
        end else begin
          state_n = IDLE;
        end
      end
      HELD: begin
        if (numpad == '0) begin
          if (DEBOUNCE_TICKS == 1) begin
            state_n = IDLE;
          end else begin
            cnt_n   = DBW'(1);
            state_n = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (numpad != '0) begin
          state_n = HELD;
        end else if (cnt == DBW'(DEBOUNCE_TICKS - 1)) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + DBW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Entry register: clear beats accept; accepts are dropped once full
  always_ff @(posedge clock_100Hz) begin
    if (reset) begin
      D           <= '0;
      digit_count <= '0;
      full        <= 1'b0;
      loadn       <= 1'b1;
    end else if (clear) begin
      D           <= '0;
      digit_count <= '0;
      full        <= 1'b0;
      loadn       <= 1'b1;
    end else if (accept_c && !full) begin
      D           <= d_shift_c;
      digit_count <= digit_count + CW'(1);
      full        <= (digit_count + CW'(1)) == CW'(NUM_DIGITS);
      loadn       <= 1'b0;
    end else begin
      loadn       <= 1'b1;
    end
  end

  assign div_next_c = (div_cnt == DIVW'(DIV_COUNT - 1)) ? '0 : div_cnt + DIVW'(1);

  // Free-running divider; output follows the upper half of the count
  always_ff @(posedge clock_100Hz) begin
    if (reset) begin
      div_cnt <= '0;
      pgt_1Hz <= 1'b0;
    end else begin
      div_cnt <= div_next_c;
      pgt_1Hz <= div_next_c >= DIVW'(DIV_COUNT / 2);
    end
  end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed self-checking bench for keypad_time_entry (default parameters).
module tb_keypad_time_entry;

  logic        clock_100Hz = 1'b0;
  logic        reset;
  logic [9:0]  numpad;
  logic        enablen;
  logic        clear;
  logic [15:0] D;
  logic [2:0]  digit_count;
  logic        loadn;
  logic        full;
  logic        pgt_1Hz;

  int tests = 0;
  int fails = 0;

  keypad_time_entry dut (
    .clock_100Hz (clock_100Hz),
    .reset       (reset),
    .numpad      (numpad),
    .enablen     (enablen),
    .clear       (clear),
    .D           (D),
    .digit_count (digit_count),
    .loadn       (loadn),
    .full        (full),
    .pgt_1Hz     (pgt_1Hz)
  );

  // 10 time-unit clock
  always #5 clock_100Hz = ~clock_100Hz;

  task automatic tick();
    @(posedge clock_100Hz);
    #1;
  endtask

  // Press one key for hold cycles, release for rel cycles, count load strobes
  task automatic press_key(input int key, input int hold, input int rel, output int lows);
    lows   = 0;
    numpad = 10'b1 << key;
    repeat (hold) begin
      tick();
      if (loadn === 1'b0) lows++;
    end
    numpad = '0;
    repeat (rel) begin
      tick();
      if (loadn === 1'b0) lows++;
    end
  endtask

  task automatic test_reset();
    int lows;
    reset = 1'b1; enablen = 1'b1; numpad = '0; clear = 1'b0;
    tick(); tick();
    tests++;
    if (D !== 16'h0 || digit_count !== 3'd0 || loadn !== 1'b1 || full !== 1'b0 || pgt_1Hz !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: D=%h cnt=%0d loadn=%b full=%b pgt=%b, want 0000 0 1 0 0",
               D, digit_count, loadn, full, pgt_1Hz);
    end
    reset = 1'b0;
    numpad = 10'b0000000001;
    lows = 0;
    repeat (20) begin
      tick();
      if (loadn === 1'b0) lows++;
    end
    tests++;
    if (lows !== 0 || D !== 16'h0 || digit_count !== 3'd0) begin
      fails++;
      $display("FAIL disabled_entry: lows=%0d D=%h cnt=%0d, want 0 0000 0", lows, D, digit_count);
    end
  endtask

  task automatic test_single_key();
    int lows, first;
    lows = 0; first = -1;
    enablen = 1'b0;
    numpad  = 10'b0000000010;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (loadn === 1'b0) begin
        lows++;
        if (first < 0) first = i;
      end
    end
    tests++;
    if (lows !== 1 || first !== 3) begin
      fails++;
      $display("FAIL single_strobe: lows=%0d first_edge=%0d, want 1 at 3", lows, first);
    end
    tests++;
    if (D !== 16'h0001 || digit_count !== 3'd1) begin
      fails++;
      $display("FAIL single_value: D=%h cnt=%0d, want 0001 1", D, digit_count);
    end
  endtask

  task automatic test_sequence();
    int lows, total;
    numpad = '0;
    repeat (10) tick();
    total = 0;
    press_key(2, 5, 5, lows); total += lows;
    press_key(5, 5, 5, lows); total += lows;
    tests++;
    if (D !== 16'h0125 || digit_count !== 3'd3 || total !== 2) begin
      fails++;
      $display("FAIL sequence: D=%h cnt=%0d strobes=%0d, want 0125 3 2", D, digit_count, total);
    end
    press_key(2, 2, 5, lows);
    tests++;
    if (lows !== 0 || D !== 16'h0125 || digit_count !== 3'd3) begin
      fails++;
      $display("FAIL bounce: strobes=%0d D=%h cnt=%0d, want 0 0125 3", lows, D, digit_count);
    end
  endtask

  task automatic test_full();
    int lows;
    clear = 1'b1; tick(); clear = 1'b0;
    tests++;
    if (D !== 16'h0 || digit_count !== 3'd0) begin
      fails++;
      $display("FAIL clear_pre: D=%h cnt=%0d, want 0000 0", D, digit_count);
    end
    for (int k = 1; k <= 4; k++) press_key(k, 4, 4, lows);
    tests++;
    if (D !== 16'h1234 || digit_count !== 3'd4 || full !== 1'b1) begin
      fails++;
      $display("FAIL fill: D=%h cnt=%0d full=%b, want 1234 4 1", D, digit_count, full);
    end
    press_key(7, 4, 4, lows);
    tests++;
    if (lows !== 0 || D !== 16'h1234 || digit_count !== 3'd4) begin
      fails++;
      $display("FAIL overflow: strobes=%0d D=%h cnt=%0d, want 0 1234 4", lows, D, digit_count);
    end
    clear = 1'b1; tick(); clear = 1'b0;
    tests++;
    if (D !== 16'h0 || digit_count !== 3'd0 || full !== 1'b0) begin
      fails++;
      $display("FAIL clear_full: D=%h cnt=%0d full=%b, want 0000 0 0", D, digit_count, full);
    end
  endtask

  task automatic test_multi_key_and_clear();
    int lows;
    lows = 0;
    numpad = 10'b0000000110;
    repeat (20) begin
      tick();
      if (loadn === 1'b0) lows++;
    end
    tests++;
    if (lows !== 0 || D !== 16'h0 || digit_count !== 3'd0) begin
      fails++;
      $display("FAIL two_keys: strobes=%0d D=%h cnt=%0d, want 0 0000 0", lows, D, digit_count);
    end
    numpad = '0; tick(); tick();
    press_key(8, 4, 4, lows);
    tests++;
    if (D !== 16'h0008 || digit_count !== 3'd1) begin
      fails++;
      $display("FAIL key8: D=%h cnt=%0d, want 0008 1", D, digit_count);
    end
    numpad = 10'b1000000000;
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++;
    if (loadn !== 1'b1 || D !== 16'h0 || digit_count !== 3'd0) begin
      fails++;
      $display("FAIL clear_vs_accept: loadn=%b D=%h cnt=%0d, want 1 0000 0", loadn, D, digit_count);
    end
    lows = 0;
    repeat (5) begin
      tick();
      if (loadn === 1'b0) lows++;
    end
    tests++;
    if (lows !== 0 || digit_count !== 3'd0) begin
      fails++;
      $display("FAIL held_after_clear: strobes=%0d cnt=%0d, want 0 0", lows, digit_count);
    end
    numpad = '0;
    repeat (4) tick();
  endtask

  task automatic test_divider();
    logic exp;
    reset = 1'b1; tick();
    tests++;
    if (pgt_1Hz !== 1'b0) begin
      fails++;
      $display("FAIL div_reset: pgt=%b, want 0", pgt_1Hz);
    end
    reset = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      tick();
      exp = ((k % 100) >= 50);
      tests++;
      if (pgt_1Hz !== exp) begin
        fails++;
        $display("FAIL div_edge_%0d: pgt=%b, want %b", k, pgt_1Hz, exp);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    int lows, first;
    press_key(4, 4, 4, lows);
    tests++;
    if (D !== 16'h0004 || digit_count !== 3'd1) begin
      fails++;
      $display("FAIL pre_reset: D=%h cnt=%0d, want 0004 1", D, digit_count);
    end
    numpad = 10'b0000001000;
    tick(); tick();
    reset = 1'b1;
    tick();
    tests++;
    if (D !== 16'h0 || digit_count !== 3'd0 || loadn !== 1'b1 || full !== 1'b0 || pgt_1Hz !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: D=%h cnt=%0d loadn=%b full=%b pgt=%b, want 0000 0 1 0 0",
               D, digit_count, loadn, full, pgt_1Hz);
    end
    reset = 1'b0;
    lows = 0; first = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (loadn === 1'b0) begin
        lows++;
        if (first < 0) first = i;
      end
    end
    tests++;
    if (lows !== 1 || first !== 3 || D !== 16'h0003) begin
      fails++;
      $display("FAIL restart: strobes=%0d first=%0d D=%h, want 1 3 0003", lows, first, D);
    end
    numpad = '0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_sequence();
    test_full();
    test_multi_key_and_clear();
    test_divider();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
